fetch_decode_stage: RTL
=======================

Name: fetch_decode_stage

Overview:
- Y86-64 fetch stage plus the D pipeline register it feeds.
- Takes the F-register predicted PC and M/W-stage redirect information, then selects the fetch PC.
- Reads a byte-addressed instruction memory, splits and aligns the instruction, computes valP and the next predicted PC, and latches the result into the D register under stall/bubble control.
- Returns f_predPC to the F register.

Parameters:
IMEM_BYTES, 1024, instruction memory size in bytes; valid byte addresses are 0..IMEM_BYTES-1.
ADDR_W, 64, PC/address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
F_predPC  in  64  predicted PC from the F register.
M_icode  in  4  icode in the M stage.
M_Cnd  in  1  branch condition in the M stage.
M_valA  in  64  fall-through PC of a mispredicted jXX.
W_icode  in  4  icode in the W stage.
W_valM  in  64  return address popped by ret.
D_stall  in  1  hold the D register.
D_bubble  in  1  load a nop bubble into the D register.
imem_we  in  1  instruction memory byte write enable (program load).
imem_waddr  in  64  write byte address.
imem_wdata  in  8  write byte.
f_pc  out  64  selected fetch PC (combinational).
f_predPC  out  64  next predicted PC, to the F register (combinational).
f_stat  out  4  fetch status (combinational).
D_stat, D_icode, D_ifun, D_rA, D_rB  out  4 each  D register fields.
D_valC, D_valP  out  64 each  D register fields.

Behaviour:
- Status encodings: AOK=1, HLT=2, ADR=3, INS=4.
- Icode encodings: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.

PC select, in priority order:
- M_icode==7 && !M_Cnd -> M_valA.
- Else W_icode==9 -> W_valM.
- Else F_predPC.

Decode of the fetched instruction:
- byte0 = mem[f_pc]; icode = byte0[7:4], ifun = byte0[3:0].
- need_regids for icode in {2,3,4,5,6,A,B}. When set, rA = byte1[7:4] and rB = byte1[3:0]; otherwise rA = rB = 4'hF.
- need_valC for icode in {3,4,5,7,8}. valC is 8 bytes, little-endian, starting at f_pc+1+need_regids; otherwise valC = 0.
- valP = f_pc + 1 + need_regids + 8*need_valC.

Error and status rules:
- imem_error is set if any byte the instruction occupies (f_pc .. valP-1) is >= IMEM_BYTES.
- On imem_error: icode forced to 1 and ifun to 0; f_stat=ADR.
- Else icode > B -> f_stat=INS.
- Else icode==0 -> f_stat=HLT.
- Else f_stat=AOK.

Next-PC prediction:
- f_predPC = valC for icode 7 or 8.
- f_predPC = f_pc when f_stat is not AOK, so fetch freezes.
- Otherwise f_predPC = valP.

D register:
- Async reset drives D_stat=1, D_icode=1, D_ifun=0, D_rA=D_rB=F, D_valC=0, D_valP=0.
- On each rising edge:
  - D_stall=1 -> hold. Stall overrides bubble when both are asserted.
  - Else D_bubble=1 -> load the reset/bubble values.
  - Else load f_stat, icode, ifun, rA, rB, valC, valP.
- Latency: the fetched instruction appears on D_* one cycle after its f_pc is presented.
- A reset asserted mid-operation immediately forces D to bubble values regardless of clk.

Instruction memory:
- Byte array, combinational reads, synchronous writes on the rising edge when imem_we is set.
- Writes with imem_waddr >= IMEM_BYTES are ignored.
- A read of the byte being written in the same cycle returns the old data.
- Memory contents are not cleared by rst.

Arithmetic:
- All PC arithmetic is 64-bit unsigned and wraps modulo 2^64.
- A wrapped address counts as an imem_error through the bounds check.

Test Plan:
- Load 30 F4 08 00 00 00 00 00 00 00 (irmovq $8,%rsp) at 0, F_predPC=0, no stall/bubble -> f_predPC=10. After the edge: D_icode=3, D_rA=F, D_rB=4, D_valC=8, D_valP=10, D_stat=1.
- jXX at 0x20 targeting 0x100 -> f_predPC=0x100. Then M_icode=7, M_Cnd=0, M_valA=0x29 -> f_pc=0x29. With W_icode=9 also asserted, the M redirect still wins.
- W_icode=9, W_valM=0x40, M not redirecting -> f_pc=0x40, and the instruction at 0x40 is latched.
- rmmovq placed at IMEM_BYTES-5 -> f_stat=3, D_icode=1 after the edge, f_predPC=f_pc. Byte 0xC0 at address 0 -> f_stat=4. Byte 0x00 at address 0 -> f_stat=2.
- Load a nop, then hold D_stall=1 for 2 cycles with a new F_predPC -> D unchanged. With D_bubble=1 and D_stall=0 -> D_icode=1, D_valP=0. With both asserted -> D holds.
- Assert rst between clock edges with D holding an irmovq -> D reads bubble values immediately. imem contents are intact after rst deasserts.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// ---------------------------------------------------------------------------
// fetch_decode_stage
//
// Y86-64 fetch stage plus the D pipeline register it feeds.
//
// The fetch PC is chosen from the M-stage mispredict redirect, then the
// W-stage ret return address, then the F-register prediction. The stage
// reads up to ten bytes from a small byte-addressed instruction memory,
// splits them into icode/ifun/rA/rB/valC, and computes valP and the next
// predicted PC. The result is latched into the D register under stall and
// bubble control.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   F_predPC                 predicted PC held in the F register
//   M_icode, M_Cnd, M_valA   M-stage mispredict redirect information
//   W_icode, W_valM          W-stage ret return address
//   D_stall, D_bubble        D register hold / nop injection
//   imem_we/waddr/wdata      byte write port used for program load
//   f_pc, f_predPC, f_stat   combinational fetch results
//   D_*                      D register fields
// ---------------------------------------------------------------------------
module fetch_decode_stage #(
    parameter int IMEM_BYTES = 1024,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] F_predPC,
    input  logic [3:0]        M_icode,
    input  logic              M_Cnd,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_valM,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [7:0]        imem_wdata,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] f_predPC,
    output logic [3:0]        f_stat,
    output logic [3:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [ADDR_W-1:0] D_valC,
    output logic [ADDR_W-1:0] D_valP
);

    localparam int IDX_W = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(IMEM_BYTES);

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    // -----------------------------------------------------------------------
    // Instruction memory: combinational read, synchronous write, not reset.
    // -----------------------------------------------------------------------
    logic [7:0] mem [IMEM_BYTES];

    always_ff @(posedge clk) begin
        if (imem_we && (imem_waddr < MEM_LIMIT)) begin
            mem[imem_waddr[IDX_W-1:0]] <= imem_wdata;
        end
    end

    // Out-of-range bytes read as zero so every decoded field stays defined;
    // the bounds check below is what flags the access as an error.
    function automatic logic [7:0] imem_rd(input logic [ADDR_W-1:0] addr);
        if (addr < MEM_LIMIT) begin
            return mem[addr[IDX_W-1:0]];
        end
        return 8'h00;
    endfunction

    // -----------------------------------------------------------------------
    // PC select
    // -----------------------------------------------------------------------
    always_comb begin
        if ((M_icode == I_JXX) && !M_Cnd) begin
            f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc = W_valM;
        end else begin
            f_pc = F_predPC;
        end
    end

    // -----------------------------------------------------------------------
    // Split and align
    // -----------------------------------------------------------------------
    logic [7:0]        byte0;
    logic [7:0]        byte1;
    logic [3:0]        raw_icode;
    logic [3:0]        raw_ifun;
    logic              need_regids;
    logic              need_valc;
    logic [ADDR_W-1:0] valc_base;
    logic [ADDR_W-1:0] f_valC;
    logic [ADDR_W-1:0] f_valP;
    logic [ADDR_W-1:0] last_byte;
    logic              imem_error;
    logic [3:0]        f_icode;
    logic [3:0]        f_ifun;
    logic [3:0]        f_rA;
    logic [3:0]        f_rB;

    assign byte0     = imem_rd(f_pc);
    assign byte1     = imem_rd(f_pc + ADDR_W'(1));
    assign raw_icode = byte0[7:4];
    assign raw_ifun  = byte0[3:0];

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (raw_icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            I_JXX, I_CALL: need_valc = 1'b1;
            default: begin
                need_regids = 1'b0;
                need_valc   = 1'b0;
            end
        endcase
    end

    assign valc_base = f_pc + ADDR_W'(1) + ADDR_W'(need_regids);

    always_comb begin
        f_valC = '0;
        if (need_valc) begin
            for (int i = 0; i < 8; i++) begin
                f_valC[8*i +: 8] = imem_rd(valc_base + ADDR_W'(i));
            end
        end
    end

    assign f_valP    = valc_base + (need_valc ? ADDR_W'(8) : ADDR_W'(0));
    assign last_byte = f_valP - ADDR_W'(1);

    // The instruction spans f_pc..last_byte. last_byte < f_pc means the span
    // wrapped past 2^64, which can only land on an out-of-range address.
    assign imem_error = (f_pc >= MEM_LIMIT) || (last_byte >= MEM_LIMIT) ||
                        (last_byte < f_pc);

    assign f_icode = imem_error ? I_NOP : raw_icode;
    assign f_ifun  = imem_error ? 4'h0  : raw_ifun;
    assign f_rA    = need_regids ? byte1[7:4] : REG_NONE;
    assign f_rB    = need_regids ? byte1[3:0] : REG_NONE;

    always_comb begin
        if (imem_error) begin
            f_stat = STAT_ADR;
        end else if (raw_icode > I_POPQ) begin
            f_stat = STAT_INS;
        end else if (raw_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end
    end

    // Non-AOK fetches repeat the same PC so the front end freezes on the fault.
    always_comb begin
        if ((f_icode == I_JXX) || (f_icode == I_CALL)) begin
            f_predPC = f_valC;
        end else if (f_stat != STAT_AOK) begin
            f_predPC = f_pc;
        end else begin
            f_predPC = f_valP;
        end
    end

    // -----------------------------------------------------------------------
    // D pipeline register. Stall takes priority over bubble.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D_stat  <= STAT_AOK;
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= '0;
            D_valP  <= '0;
        end else if (D_stall) begin
            D_stat  <= D_stat;
            D_icode <= D_icode;
            D_ifun  <= D_ifun;
            D_rA    <= D_rA;
            D_rB    <= D_rB;
            D_valC  <= D_valC;
            D_valP  <= D_valP;
        end else if (D_bubble) begin
            D_stat  <= STAT_AOK;
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= '0;
            D_valP  <= '0;
        end else begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
        end
    end

endmodule
